hbridge_ctrl: RTL
=================

HBRIDGE_CTRL -- requirements
Module: hbridge_ctrl

Interface
REQ-001 The module SHALL have parameter DEADTIME_CYC, default 21'd100000: coast cycles on a direction reversal.
REQ-002 The module SHALL have parameter HOLDOFF_CYC, default 21'd1000000: coast cycles after an overcurrent fault.
REQ-003 The module SHALL have parameter OCP_FILTER, default 4: consecutive low samples of synchronized ocp_n that declare a fault; legal range 1..15.
REQ-004 The module SHALL have parameter MAX_RETRIES, default 3: the fault count at which the block enters LOCKOUT; legal range 1..7.
REQ-005 The module SHALL have port clk, input, 1 bit: system clock, rising edge.
REQ-006 The module SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-007 The module SHALL have port pwm_in, input, 1 bit: duty waveform from the PWM generator, synchronous to clk.
REQ-008 The module SHALL have port enable, input, 1 bit: motor run request.
REQ-009 The module SHALL have port dir_req, input, 1 bit: requested direction (1 = forward); asynchronous switch.
REQ-010 The module SHALL have port ocp_n, input, 1 bit: overcurrent comparator, active-low; asynchronous.
REQ-011 The module SHALL have ports in1 and in2, outputs, 1 bit each: bridge direction pins.
REQ-012 The module SHALL have port ena, output, 1 bit: bridge enable pin, gated PWM.
REQ-013 The module SHALL have port fault, output, 1 bit: high in FAULT_WAIT or LOCKOUT.
REQ-014 The module SHALL have port lockout, output, 1 bit: high in LOCKOUT only.

Function
REQ-015 dir_req and ocp_n SHALL each pass through a 2-flop synchronizer; the synchronized values are dir_s and ocp_s.
REQ-016 Filter counter: increments while ocp_s=0, saturates, clears when ocp_s=1; fault_det = (ocp_s=0 and count=OCP_FILTER-1).
REQ-017 FSM states SHALL be IDLE, RUN, DEAD, FAULT_WAIT, LOCKOUT.
REQ-018 IDLE: enable=1 -> RUN, and dir_active <= dir_s.
REQ-019 RUN exits in priority order: fault_det -> fault path; else enable=0 -> IDLE; else dir_s != dir_active -> DEAD with timer loaded.
REQ-020 DEAD exits in priority order: fault_det -> fault path; else enable=0 -> IDLE; else after DEADTIME_CYC cycles in DEAD -> RUN, with dir_active <= dir_s sampled at exit.
REQ-021 Fault path: fault_cnt increments (3-bit); the new value = MAX_RETRIES -> LOCKOUT, otherwise -> FAULT_WAIT with timer loaded to HOLDOFF_CYC.
REQ-022 FAULT_WAIT SHALL ignore enable and dir_s until the timer expires, after exactly HOLDOFF_CYC cycles; it then goes to RUN (dir_active <= dir_s) if enable=1, else IDLE.
REQ-023 LOCKOUT: stays until enable=0, then -> IDLE.
REQ-024 fault_cnt SHALL clear whenever the state is IDLE.
REQ-025 The 21-bit down-counter timer SHALL be shared by DEAD and FAULT_WAIT.
REQ-026 All outputs SHALL be registered and computed from next state, so they change on the same edge as the state.
REQ-027 In RUN: ena = pwm_in, delayed 1 cycle; in1 = dir_active; in2 = ~dir_active.
REQ-028 In every other state: ena=0, in1=0, in2=0 (coast); in1 and in2 SHALL never both be 1.
REQ-029 Fault latency: ena=0 on edge OCP_FILTER+2, counting from the first edge that samples ocp_n=0 (edge 6 at default).
REQ-030 A dir_s toggle back during DEAD SHALL NOT restart the timer; DEAD completes, then RUN uses the current dir_s.

Reset
REQ-031 Reset SHALL force state=IDLE; in1=in2=ena=fault=lockout=0; fault_cnt=0; timer=0; filter count=0; dir_active=1; synchronizer flops=1.
REQ-032 Reset mid-DEAD, mid-FAULT_WAIT or in LOCKOUT SHALL take effect on the next edge; outputs coast.

Structure
REQ-033 Package motor_pkg SHALL hold the state enum typedef and default constants for DEADTIME_CYC, HOLDOFF_CYC, OCP_FILTER and MAX_RETRIES.
REQ-034 The 2-flop synchronizer SHALL be a sub-module, sync2, instantiated twice; the remaining logic stays flat.

Verification
Bench parameters: DEADTIME_CYC=8, HOLDOFF_CYC=16, OCP_FILTER=4, MAX_RETRIES=3.
REQ-035 enable=1, dir_req=1, pwm_in toggling -> in1=1, in2=0, ena follows pwm_in by 1 cycle.
REQ-036 Flip dir_req to 0 in RUN -> ena=in1=in2=0 for exactly 8 cycles, then in1=0, in2=1, ena resumes.
REQ-037 ocp_n low for 3 cycles then high -> no fault; low for 4 or more cycles -> fault=1 and ena=0 on edge 6.
REQ-038 Three faults with enable held at 1 -> two FAULT_WAIT periods of 16 cycles each, third fault -> lockout=1; enable=0 -> IDLE, fault=lockout=0.
REQ-039 Reset asserted mid-FAULT_WAIT -> next edge all outputs 0, state IDLE, fault_cnt=0.
REQ-040 Continuous check that in1 and in2 are never both 1 and ena=0 whenever fault=1.

Source files
------------

// File: rtl/motor_pkg.sv
// H-bridge motor control shared types.
// State encoding and default timing constants.
package motor_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DEAD,
    FAULT_WAIT,
    LOCKOUT
  } state_t;

  localparam logic [20:0] DEADTIME_CYC_DEF = 21'd100000;
  localparam logic [20:0] HOLDOFF_CYC_DEF  = 21'd1000000;
  localparam int          OCP_FILTER_DEF   = 4;
  localparam int          MAX_RETRIES_DEF  = 3;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous inputs.
// Both flops reset to RST_VAL.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the raw input through two flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/hbridge_ctrl.sv
// H-bridge direction/enable controller with dead-time,
// overcurrent filtering, retry hold-off and lockout.
module hbridge_ctrl
  import motor_pkg::*;
#(
  parameter logic [20:0] DEADTIME_CYC = DEADTIME_CYC_DEF,
  parameter logic [20:0] HOLDOFF_CYC  = HOLDOFF_CYC_DEF,
  parameter int          OCP_FILTER   = OCP_FILTER_DEF,
  parameter int          MAX_RETRIES  = MAX_RETRIES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic pwm_in,
  input  logic enable,
  input  logic dir_req,
  input  logic ocp_n,
  output logic in1,
  output logic in2,
  output logic ena,
  output logic fault,
  output logic lockout
);

  localparam logic [3:0]  FILT_MAX  = 4'(OCP_FILTER - 1);
  localparam logic [2:0]  RETRY_LIM = 3'(MAX_RETRIES);
  localparam logic [20:0] DEAD_LOAD = DEADTIME_CYC - 21'd1;
  localparam logic [20:0] HOLD_LOAD = HOLDOFF_CYC - 21'd1;

  logic        dir_s;
  logic        ocp_s;
  logic [3:0]  filt;
  logic        fault_det;

  state_t      state;
  state_t      nxt_state;
  logic        dir_active;
  logic        nxt_dir;
  logic [20:0] timer;
  logic [20:0] nxt_timer;
  logic [2:0]  fault_cnt;
  logic [2:0]  nxt_fcnt;
  logic [2:0]  fault_inc;
  logic        nxt_run;

  sync2 #(.RST_VAL(1'b1)) u_sync_dir (
    .clk   (clk),
    .reset (reset),
    .d     (dir_req),
    .q     (dir_s)
  );

  sync2 #(.RST_VAL(1'b1)) u_sync_ocp (
    .clk   (clk),
    .reset (reset),
    .d     (ocp_n),
    .q     (ocp_s)
  );

  // Count consecutive low samples, holding at the trip value.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt <= '0;
    end else if (ocp_s) begin
      filt <= '0;
    end else if (filt != FILT_MAX) begin
      filt <= filt + 4'd1;
    end
  end

  assign fault_det = !ocp_s && (filt == FILT_MAX);
  assign fault_inc = fault_cnt + 3'd1;
  assign nxt_run   = (nxt_state == RUN);

  // Next-state, timer, direction and retry-count decode.
  always_comb begin
    nxt_state = state;
    nxt_dir   = dir_active;
    nxt_timer = timer;
    nxt_fcnt  = fault_cnt;
    unique case (state)
      IDLE: begin
        if (enable) begin
          nxt_state = RUN;
          nxt_dir   = dir_s;
        end
      end
      RUN: begin
        if (!enable) begin
          nxt_state = IDLE;
        end else if (dir_s != dir_active) begin
          nxt_state = DEAD;
          nxt_timer = DEAD_LOAD;
        end
      end
      DEAD: begin
        if (!enable) begin
          nxt_state = IDLE;
        end else if (timer == '0) begin
          nxt_state = RUN;
          nxt_dir   = dir_s;
        end else begin
          nxt_timer = timer - 21'd1;
        end
      end
      FAULT_WAIT: begin
        if (timer == '0) begin
          nxt_state = enable ? RUN : IDLE;
          nxt_dir   = enable ? dir_s : dir_active;
        end else begin
          nxt_timer = timer - 21'd1;
        end
      end
      LOCKOUT: begin
        if (!enable) nxt_state = IDLE;
      end
      default: nxt_state = IDLE;
    endcase
    // Overcurrent wins over every other exit from RUN/DEAD.
    if (fault_det && (state == RUN || state == DEAD)) begin
      nxt_fcnt  = fault_inc;
      nxt_dir   = dir_active;
      nxt_timer = HOLD_LOAD;
      nxt_state = (fault_inc == RETRY_LIM) ? LOCKOUT : FAULT_WAIT;
    end
    if (nxt_state == IDLE) nxt_fcnt = '0;
  end

  // Register state and derive bridge pins from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      dir_active <= 1'b1;
      timer      <= '0;
      fault_cnt  <= '0;
      in1        <= 1'b0;
      in2        <= 1'b0;
      ena        <= 1'b0;
      fault      <= 1'b0;
      lockout    <= 1'b0;
    end else begin
      state      <= nxt_state;
      dir_active <= nxt_dir;
      timer      <= nxt_timer;
      fault_cnt  <= nxt_fcnt;
      in1        <= nxt_run && nxt_dir;
      in2        <= nxt_run && !nxt_dir;
      ena        <= nxt_run && pwm_in;
      fault      <= (nxt_state == FAULT_WAIT) ||
                    (nxt_state == LOCKOUT);
      lockout    <= (nxt_state == LOCKOUT);
    end
  end

endmodule
